// File: rtl/counter_pkg.sv
// Shared types for the counter bank: channel mode encoding and ONESHOT state.
package counter_pkg;

  typedef enum logic [1:0] {
    WRAP    = 2'd0,
    SAT     = 2'd1,
    ONESHOT = 2'd2
  } mode_e;

  typedef enum logic {
    RUN  = 1'b0,
    DONE = 1'b1
  } os_state_e;

  // The reserved encoding 3 falls through to WRAP.
  function automatic mode_e decode_mode(input logic [1:0] raw);
    case (raw)
      2'd1:    return SAT;
      2'd2:    return ONESHOT;
      default: return WRAP;
    endcase
  endfunction

endpackage

// File: rtl/counter_chan.sv
// One counter channel: clear/load/count priority, boundary detection,
// terminal-event pulse, sticky overflow and the ONESHOT run/done state.
module counter_chan
  import counter_pkg::*;
#(
  parameter int WIDTH_COUNT = 64
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   clr,
  input  logic                   en,
  input  logic                   dn,
  input  logic                   ld,
  input  logic [WIDTH_COUNT-1:0] ld_val,
  input  logic [WIDTH_COUNT-1:0] limit,
  input  logic [1:0]             mode,
  output logic [WIDTH_COUNT-1:0] count,
  output logic                   term,
  output logic                   ovf
);

  mode_e                  mode_d;
  os_state_e              state;
  os_state_e              state_nxt;
  logic [WIDTH_COUNT-1:0] count_nxt;
  logic                   term_nxt;
  logic                   ovf_nxt;
  logic                   at_bound;
  logic                   halted;

  assign mode_d   = decode_mode(mode);
  assign at_bound = dn ? (count == '0) : (count == limit);
  assign halted   = (mode_d == ONESHOT) && (state == DONE);

  always_comb begin
    // NOTE: every output of this block gets a default first so no path can infer a latch.
    count_nxt = count;
    term_nxt  = 1'b0;
    ovf_nxt   = ovf;
    state_nxt = state;

    if (clr) begin
      count_nxt = '0;
      ovf_nxt   = 1'b0;
      state_nxt = RUN;
    end else if (ld) begin
      count_nxt = ld_val;
      state_nxt = RUN;
    end else if (en && !halted) begin
      if (at_bound) begin
        term_nxt = 1'b1;
        ovf_nxt  = 1'b1;
        case (mode_d)
          WRAP:    count_nxt = dn ? limit : '0;
          ONESHOT: state_nxt = DONE;
          default: count_nxt = count;
        endcase
      end else begin
        count_nxt = dn ? count - 1'b1 : count + 1'b1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    // NOTE: state registers use non-blocking assignments so all flops update together.
    if (reset) begin
      count <= '0;
      term  <= 1'b0;
      ovf   <= 1'b0;
      state <= RUN;
    end else begin
      count <= count_nxt;
      term  <= term_nxt;
      ovf   <= ovf_nxt;
      state <= state_nxt;
    end
  end

endmodule

// File: rtl/counter_bank.sv
// Bank of NUM_CH independent counter channels with a common snapshot register
// that captures all live counts in one cycle.
module counter_bank
  import counter_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int WIDTH_COUNT = 64
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [NUM_CH-1:0]             I_Clr,
  input  logic [NUM_CH-1:0]             I_En,
  input  logic [NUM_CH-1:0]             I_Dn,
  input  logic [NUM_CH-1:0]             I_Ld,
  input  logic [NUM_CH*WIDTH_COUNT-1:0] I_LdVal,
  input  logic [NUM_CH*WIDTH_COUNT-1:0] I_Limit,
  input  logic [NUM_CH*2-1:0]           I_Mode,
  input  logic                          I_Snap,
  output logic [NUM_CH*WIDTH_COUNT-1:0] O_CountVal,
  output logic [NUM_CH-1:0]             O_Term,
  output logic [NUM_CH-1:0]             O_Ovf,
  output logic [NUM_CH*WIDTH_COUNT-1:0] O_SnapVal,
  output logic                          O_SnapVld
);

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_chan
    counter_chan #(
      .WIDTH_COUNT(WIDTH_COUNT)
    ) u_chan (
      .clock  (clock),
      .reset  (reset),
      .clr    (I_Clr[ch]),
      .en     (I_En[ch]),
      .dn     (I_Dn[ch]),
      .ld     (I_Ld[ch]),
      .ld_val (I_LdVal[ch*WIDTH_COUNT +: WIDTH_COUNT]),
      .limit  (I_Limit[ch*WIDTH_COUNT +: WIDTH_COUNT]),
      .mode   (I_Mode[2*ch +: 2]),
      .count  (O_CountVal[ch*WIDTH_COUNT +: WIDTH_COUNT]),
      .term   (O_Term[ch]),
      .ovf    (O_Ovf[ch])
    );
  end

  // Captures the counts visible in the request cycle, not the post-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      O_SnapVal <= '0;
      O_SnapVld <= 1'b0;
    end else begin
      O_SnapVld <= I_Snap;
      if (I_Snap) O_SnapVal <= O_CountVal;
    end
  end

endmodule
